// File: rtl/regfile_mp_sb_pkg.sv
// Shared types and defaults for the multi-port register file with busy scoreboard.
package regfile_pkg;

  localparam int unsigned DefDataW = 12;
  localparam int unsigned DefDepth = 4;
  localparam int unsigned DefNumRd = 2;

  typedef enum logic [1:0] {CLR_IDLE, CLR_RUN, CLR_DONE} clr_state_t;

  // An address is live if it names a real entry that is not the hardwired zero register.
  function automatic logic addr_live(int unsigned addr, int unsigned depth, logic zero_reg);
    return (addr < depth) && !(zero_reg && (addr == 0));
  endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// Decode/writeback-facing bus of the register file: write, issue, read ports and clear control.
interface regfile_mp_sb_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned DEPTH  = DefDepth,
  parameter int unsigned NUM_RD = DefNumRd
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic                           we;
  logic [AW-1:0]                  waddr;
  logic [DATA_W-1:0]              wdata;
  logic [NUM_RD-1:0][AW-1:0]      raddr;
  logic [NUM_RD-1:0][DATA_W-1:0]  rdata;
  logic [NUM_RD-1:0]              rd_busy;
  logic                           issue_en;
  logic [AW-1:0]                  issue_rd;
  logic                           clr_req;
  logic                           clr_busy;
  logic                           clr_done;

  modport master (
    output we, waddr, wdata, raddr, issue_en, issue_rd, clr_req,
    input  rdata, rd_busy, clr_busy, clr_done
  );

  modport slave (
    input  we, waddr, wdata, raddr, issue_en, issue_rd, clr_req,
    output rdata, rd_busy, clr_busy, clr_done
  );

endinterface

// File: rtl/regfile_mp_sb_clear_seq.sv
// Clear sequencer: walks every entry once, then pulses clr_done for a single cycle.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int unsigned DEPTH = DefDepth,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  output logic          clr_en,
  output logic [AW-1:0] clr_ptr,
  output logic          clr_busy,
  output logic          clr_done
);

  localparam logic [AW-1:0] LastPtr = AW'(DEPTH - 1);

  clr_state_t    state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLR_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_en  = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d = CLR_RUN;
          ptr_d   = '0;
        end
      end
      CLR_RUN: begin
        clr_en = 1'b1;
        if (ptr_q == LastPtr) begin
          state_d = CLR_DONE;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      CLR_DONE: state_d = CLR_IDLE;
      default:  state_d = CLR_IDLE;
    endcase
  end

  assign clr_ptr  = ptr_q;
  assign clr_busy = (state_q != CLR_IDLE);
  assign clr_done = (state_q == CLR_DONE);

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with per-entry busy scoreboard and clear sequencer.
// Define REGFILE_BYPASS_EN to forward same-cycle write data to matching read ports.
module regfile_mp_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned DEPTH    = DefDepth,
  parameter int unsigned NUM_RD   = DefNumRd,
  parameter int unsigned ZERO_REG = 0
) (
  input logic            clk,
  input logic            reset,
  regfile_mp_sb_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic        Zr = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;

  logic          clr_en, clr_busy, clr_done;
  logic [AW-1:0] clr_ptr;
  logic          wr_ok, iss_ok;

  regfile_clear_seq #(
    .DEPTH (DEPTH)
  ) u_clear_seq (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (bus.clr_req),
    .clr_en   (clr_en),
    .clr_ptr  (clr_ptr),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  assign wr_ok  = bus.we && !clr_busy && addr_live(32'(bus.waddr), DEPTH, Zr);
  assign iss_ok = bus.issue_en && !clr_busy && addr_live(32'(bus.issue_rd), DEPTH, Zr);

  // Issue is applied after the write so a same-cycle new producer leaves the entry busy.
  always_comb begin
    mem_d  = mem_q;
    busy_d = busy_q;
    if (clr_en) begin
      mem_d[clr_ptr]  = '0;
      busy_d[clr_ptr] = 1'b0;
    end else begin
      if (wr_ok) begin
        mem_d[bus.waddr]  = bus.wdata;
        busy_d[bus.waddr] = 1'b0;
      end
      if (iss_ok) begin
        busy_d[bus.issue_rd] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NUM_RD); i++) begin
      bus.rdata[i]   = '0;
      bus.rd_busy[i] = 1'b0;
      if (addr_live(32'(bus.raddr[i]), DEPTH, Zr)) begin
        bus.rdata[i]   = mem_q[bus.raddr[i]];
        bus.rd_busy[i] = busy_q[bus.raddr[i]];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (bus.waddr == bus.raddr[i])) begin
          bus.rdata[i]   = bus.wdata;
          bus.rd_busy[i] = 1'b0;
        end
`else
`endif
      end
    end
  end

  assign bus.clr_busy = clr_busy;
  assign bus.clr_done = clr_done;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Scoreboard bench for regfile_mp_sb: a behavioural model queues expected reads and clear status.
module tb_regfile_mp_sb;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_mp_sb_if #(.DATA_W(12), .DEPTH(4), .NUM_RD(2)) bus ();
  regfile_mp_sb_if #(.DATA_W(12), .DEPTH(4), .NUM_RD(2)) bus_z ();

  regfile_mp_sb #(
    .DATA_W(12), .DEPTH(4), .NUM_RD(2), .ZERO_REG(0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  regfile_mp_sb #(
    .DATA_W(12), .DEPTH(4), .NUM_RD(2), .ZERO_REG(1)
  ) dut_z (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_z)
  );

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } sb_item_t;
  sb_item_t sb_q[$];

  logic [11:0] m_mem [4];
  logic [3:0]  m_busy;
  int          m_st;
  int          m_ptr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic void sb_push(input string tag, input logic [31:0] exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endfunction

  task automatic sb_pop(input logic [31:0] got);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'(sb_q.size()), 1);
      return;
    end
    it = sb_q.pop_front();
    check_eq(it.tag, got, it.exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) m_mem[i] = '0;
    m_busy = '0;
    m_st   = 0;
    m_ptr  = 0;
  endfunction

  // Effect of the coming rising edge on the model, from the inputs currently driven.
  function automatic void model_update();
    case (m_st)
      0: begin
        if (bus.we) begin
          m_mem[bus.waddr]  = bus.wdata;
          m_busy[bus.waddr] = 1'b0;
        end
        if (bus.issue_en) m_busy[bus.issue_rd] = 1'b1;
        if (bus.clr_req) begin
          m_st  = 1;
          m_ptr = 0;
        end
      end
      1: begin
        m_mem[m_ptr]  = '0;
        m_busy[m_ptr] = 1'b0;
        if (m_ptr == 3) m_st = 2;
        else m_ptr++;
      end
      default: m_st = 0;
    endcase
  endfunction

  function automatic logic [31:0] exp_data(input int a);
`ifdef REGFILE_BYPASS_EN
    if (bus.we && m_st == 0 && int'(bus.waddr) == a) return 32'(bus.wdata);
`endif
    return 32'(m_mem[a]);
  endfunction

  function automatic logic [31:0] exp_busy(input int a);
`ifdef REGFILE_BYPASS_EN
    if (bus.we && m_st == 0 && int'(bus.waddr) == a) return 0;
`endif
    return 32'(m_busy[a]);
  endfunction

  task automatic tick();
    if (!reset) model_update();
    @(negedge clk);
  endtask

  task automatic drv_idle();
    bus.we = 1'b0; bus.issue_en = 1'b0; bus.clr_req = 1'b0;
  endtask

  task automatic wr(input int a, input logic [11:0] d);
    bus.we = 1'b1; bus.waddr = 2'(a); bus.wdata = d;
  endtask

  task automatic rd2(input int a0, input int a1);
    bus.raddr[0] = 2'(a0);
    bus.raddr[1] = 2'(a1);
    sb_push($sformatf("rdata0[r%0d]", a0), exp_data(a0));
    sb_push($sformatf("busy0[r%0d]", a0), exp_busy(a0));
    sb_push($sformatf("rdata1[r%0d]", a1), exp_data(a1));
    sb_push($sformatf("busy1[r%0d]", a1), exp_busy(a1));
    #1;
    sb_pop(32'(bus.rdata[0]));
    sb_pop(32'(bus.rd_busy[0]));
    sb_pop(32'(bus.rdata[1]));
    sb_pop(32'(bus.rd_busy[1]));
  endtask

  task automatic st_chk();
    sb_push("clr_busy", (reset || m_st == 0) ? 0 : 1);
    sb_push("clr_done", (!reset && m_st == 2) ? 1 : 0);
    #1;
    sb_pop(32'(bus.clr_busy));
    sb_pop(32'(bus.clr_done));
  endtask

  task automatic rd_z(input string tag, input int a, input logic [11:0] d, input logic b);
    bus_z.raddr[0] = 2'(a);
    sb_push({tag, "_data"}, 32'(d));
    sb_push({tag, "_busy"}, 32'(b));
    #1;
    sb_pop(32'(bus_z.rdata[0]));
    sb_pop(32'(bus_z.rd_busy[0]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired @%0t", $time);
    $fatal(1);
  end

  initial begin
    drv_idle();
    bus.waddr = '0; bus.wdata = '0; bus.issue_rd = '0; bus.raddr = '0;
    bus_z.we = 1'b0; bus_z.waddr = '0; bus_z.wdata = '0; bus_z.raddr = '0;
    bus_z.issue_en = 1'b0; bus_z.issue_rd = '0; bus_z.clr_req = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    st_chk();
    reset = 1'b0;

    // Reset contents on every address and both ports
    for (int a = 0; a < 4; a++) begin
      rd2(a, 3 - a);
      tick();
    end

    // Plain write, then read on both ports
    wr(2, 12'hABC);
    rd2(2, 2);
    tick();
    drv_idle();
    rd2(2, 2);

    // Scoreboard: issue, write clears, same-cycle issue+write stays busy
    bus.issue_en = 1'b1; bus.issue_rd = 2'd3;
    tick();
    drv_idle();
    rd2(3, 3);
    wr(3, 12'h055);
    tick();
    drv_idle();
    rd2(3, 3);
    wr(3, 12'h777);
    bus.issue_en = 1'b1; bus.issue_rd = 2'd3;
    tick();
    drv_idle();
    rd2(3, 0);

    // Same-cycle write vs read: bypass or old value, then new value
    wr(1, 12'h111);
    tick();
    wr(1, 12'h123);
    rd2(1, 2);
    tick();
    drv_idle();
    rd2(1, 1);

    // Full clear with a dropped write and a dropped issue mid-clear
    for (int a = 0; a < 4; a++) begin
      wr(a, 12'(12'h100 + a * 12'h011));
      tick();
    end
    drv_idle();
    bus.issue_en = 1'b1; bus.issue_rd = 2'd2;
    bus.clr_req = 1'b1;
    tick();
    drv_idle();
    for (int c = 0; c < 6; c++) begin
      st_chk();
      rd2(c % 4, 2);
      if (c == 1) wr(0, 12'hEEE);
      if (c == 2) begin
        bus.issue_en = 1'b1; bus.issue_rd = 2'd0;
      end
      tick();
      drv_idle();
    end
    for (int a = 0; a < 4; a += 2) rd2(a, a + 1);

    // clr_req held high retriggers
    bus.clr_req = 1'b1;
    for (int c = 0; c < 8; c++) begin
      st_chk();
      tick();
    end
    drv_idle();
    for (int c = 0; c < 6 && m_st != 0; c++) begin
      st_chk();
      tick();
    end
    st_chk();

    // Reset in the middle of a clear
    wr(2, 12'h5A5);
    tick();
    drv_idle();
    rd2(2, 2);
    bus.clr_req = 1'b1;
    tick();
    drv_idle();
    st_chk();
    tick();
    reset = 1'b1;
    model_reset();
    st_chk();
    rd2(2, 3);
    tick();
    reset = 1'b0;
    st_chk();
    tick();
    st_chk();
    rd2(2, 1);

    // Hardwired zero register instance
    bus_z.we = 1'b1; bus_z.waddr = 2'd0; bus_z.wdata = 12'hFFF;
    @(negedge clk);
    bus_z.waddr = 2'd1;
    rd_z("zr_r0_wr", 0, 12'h000, 1'b0);
    @(negedge clk);
    bus_z.we = 1'b0;
    bus_z.issue_en = 1'b1; bus_z.issue_rd = 2'd0;
    rd_z("zr_r1_wr", 1, 12'hFFF, 1'b0);
    @(negedge clk);
    bus_z.issue_rd = 2'd1;
    rd_z("zr_r0_iss", 0, 12'h000, 1'b0);
    @(negedge clk);
    bus_z.issue_en = 1'b0;
    rd_z("zr_r1_iss", 1, 12'hFFF, 1'b1);

    check_eq("sb_drain", 32'(sb_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
